// File: rtl/encoder_8_to_3_sequential_pkg.sv
// encoder_8_to_3_sequential_pkg: shared constants and types for the 8-to-3 event encoder
package encoder_8_to_3_sequential_pkg;
  localparam int N_LINES = 8;
  localparam int CODE_W = 3;
  typedef enum logic {IDLE = 1'b0, PRESENT = 1'b1} state_t;
  localparam logic [CODE_W-1:0] RR_PTR_RST = 3'd7;
endpackage

// File: rtl/encoder_8_to_3_sequential_pick.sv
// priority_pick_8: finds the first set bit of mask at or after start, wrapping 7 -> 0
//   mask  in  8  candidate bits
//   start in  3  index where the search begins
//   idx   out 3  index of the first set bit found
//   found out 1  mask has at least one set bit
module priority_pick_8
  import encoder_8_to_3_sequential_pkg::*;
(
  input  logic [N_LINES-1:0] mask,
  input  logic [CODE_W-1:0]  start,
  output logic [CODE_W-1:0]  idx,
  output logic               found
);
  logic [2*N_LINES-1:0] dbl;
  logic [N_LINES-1:0]   rot;
  logic [CODE_W-1:0]    off;
  // rotating right by start turns the wrapped search into a plain lowest-bit search
  assign dbl = {mask, mask} >> start;
  assign rot = dbl[N_LINES-1:0];
  always_comb begin
    off = '0;
    for (int i = N_LINES - 1; i >= 0; i--)
      if (rot[i]) off = i[CODE_W-1:0];
  end
  assign idx = start + off;
  assign found = |mask;
endmodule

// File: rtl/encoder_8_to_3_sequential.sv
// encoder_8_to_3_sequential: captures line events into sticky pending bits and drains them as 3-bit codes
//   clk       in  1  rising-edge clock
//   rst_n     in  1  asynchronous active-low reset
//   in_lines  in  8  event request lines
//   out_lines out 3  registered code of the presented event
//   out_valid out 1  registered, out_lines holds a code
//   out_ready in  1  consumer accepts on out_valid & out_ready
//   busy      out 1  pending events or a code on offer
//   dropped   out 1  one-cycle pulse after an event was lost
module encoder_8_to_3_sequential
  import encoder_8_to_3_sequential_pkg::*;
#(
  parameter bit RR_EN = 1'b0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_LINES-1:0] in_lines,
  output logic [CODE_W-1:0]  out_lines,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               busy,
  output logic               dropped
);
  state_t              state;
  logic [N_LINES-1:0]  pending, clr_mask, avail;
  logic [CODE_W-1:0]   rr_ptr, start, idx;
  logic                accept, found, load;
  assign out_valid = state == PRESENT;
  assign accept = out_valid & out_ready;
  assign clr_mask = accept ? N_LINES'(1) << out_lines : '0;
  // avail equals pending in IDLE, so one pick serves both the first load and back-to-back reloads
  assign avail = pending & ~clr_mask;
  assign start = RR_EN ? rr_ptr + 3'd1 : '0;
  assign load = (!out_valid || accept) && found;
  assign busy = |pending | out_valid;
  priority_pick_8 u_pick (
    .mask  (avail),
    .start (start),
    .idx   (idx),
    .found (found)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      pending <= '0;
      out_lines <= '0;
      dropped <= 1'b0;
      rr_ptr <= RR_PTR_RST;
    end else begin
      pending <= avail | in_lines;
      dropped <= |(in_lines & avail);
      state <= load ? PRESENT : accept ? IDLE : state;
      if (load) out_lines <= idx;
      if (load && RR_EN) rr_ptr <= idx;
    end
  end
endmodule

// File: tb/tb_encoder_8_to_3_sequential.sv
// tb_encoder_8_to_3_sequential: directed vector table plus hand sequences for round-robin and async reset
module tb_encoder_8_to_3_sequential;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] in_lines = '0;
  logic       out_ready = 1'b0;
  logic [2:0] cf, cr;
  logic       vf, vr, bf, br, df, dr;
  int         checks = 0;
  int         failures = 0;
  typedef struct {
    logic [7:0] in;
    logic       rdy;
    logic       v;
    logic [2:0] code;
    logic       drop;
    logic       busy;
  } vec_t;
  vec_t tbl[$];
  logic [2:0] rr_exp[5];
  logic [2:0] fx_exp[5];
  always #5 clk = ~clk;
  encoder_8_to_3_sequential #(.RR_EN(1'b0)) dut_fix (
    .clk(clk), .rst_n(rst_n), .in_lines(in_lines), .out_lines(cf),
    .out_valid(vf), .out_ready(out_ready), .busy(bf), .dropped(df)
  );
  encoder_8_to_3_sequential #(.RR_EN(1'b1)) dut_rr (
    .clk(clk), .rst_n(rst_n), .in_lines(in_lines), .out_lines(cr),
    .out_valid(vr), .out_ready(out_ready), .busy(br), .dropped(dr)
  );
  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic cyc(input logic [7:0] i, input logic r);
    in_lines = i;
    out_ready = r;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    in_lines = '0;
    out_ready = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask
  initial begin
    // single event on line 5
    tbl.push_back('{8'h20, 1'b1, 1'b0, 3'd0, 1'b0, 1'b1});
    tbl.push_back('{8'h00, 1'b1, 1'b1, 3'd5, 1'b0, 1'b1});
    tbl.push_back('{8'h00, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0});
    tbl.push_back('{8'h00, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0});
    // fixed-priority drain of lines 1, 3, 7
    tbl.push_back('{8'h8A, 1'b1, 1'b0, 3'd0, 1'b0, 1'b1});
    tbl.push_back('{8'h00, 1'b1, 1'b1, 3'd1, 1'b0, 1'b1});
    tbl.push_back('{8'h00, 1'b1, 1'b1, 3'd3, 1'b0, 1'b1});
    tbl.push_back('{8'h00, 1'b1, 1'b1, 3'd7, 1'b0, 1'b1});
    tbl.push_back('{8'h00, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0});
    // backpressure on code 2 while line 0 pulses
    tbl.push_back('{8'h04, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1});
    tbl.push_back('{8'h00, 1'b0, 1'b1, 3'd2, 1'b0, 1'b1});
    tbl.push_back('{8'h01, 1'b0, 1'b1, 3'd2, 1'b0, 1'b1});
    tbl.push_back('{8'h00, 1'b0, 1'b1, 3'd2, 1'b0, 1'b1});
    tbl.push_back('{8'h01, 1'b0, 1'b1, 3'd2, 1'b1, 1'b1});
    tbl.push_back('{8'h00, 1'b0, 1'b1, 3'd2, 1'b0, 1'b1});
    tbl.push_back('{8'h00, 1'b1, 1'b1, 3'd0, 1'b0, 1'b1});
    tbl.push_back('{8'h00, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0});
    // overflow on line 4, delivered once
    tbl.push_back('{8'h10, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1});
    tbl.push_back('{8'h00, 1'b0, 1'b1, 3'd4, 1'b0, 1'b1});
    tbl.push_back('{8'h10, 1'b0, 1'b1, 3'd4, 1'b1, 1'b1});
    tbl.push_back('{8'h00, 1'b0, 1'b1, 3'd4, 1'b0, 1'b1});
    tbl.push_back('{8'h00, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0});
    tbl.push_back('{8'h00, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0});
    // set beats clear on line 4
    tbl.push_back('{8'h10, 1'b1, 1'b0, 3'd0, 1'b0, 1'b1});
    tbl.push_back('{8'h00, 1'b1, 1'b1, 3'd4, 1'b0, 1'b1});
    tbl.push_back('{8'h10, 1'b1, 1'b0, 3'd0, 1'b0, 1'b1});
    tbl.push_back('{8'h00, 1'b1, 1'b1, 3'd4, 1'b0, 1'b1});
    tbl.push_back('{8'h00, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0});
    rr_exp = '{3'd0, 3'd1, 3'd2, 3'd0, 3'd1};
    fx_exp = '{3'd0, 3'd1, 3'd0, 3'd1, 3'd0};
    #2;
    chk("rst_valid", {7'd0, vf}, 8'd0);
    chk("rst_lines", {5'd0, cf}, 8'd0);
    chk("rst_busy", {7'd0, bf}, 8'd0);
    chk("rst_dropped", {7'd0, df}, 8'd0);
    do_reset();
    foreach (tbl[i]) begin
      cyc(tbl[i].in, tbl[i].rdy);
      chk($sformatf("vec%0d_valid", i), {7'd0, vf}, {7'd0, tbl[i].v});
      chk($sformatf("vec%0d_dropped", i), {7'd0, df}, {7'd0, tbl[i].drop});
      chk($sformatf("vec%0d_busy", i), {7'd0, bf}, {7'd0, tbl[i].busy});
      if (tbl[i].v) chk($sformatf("vec%0d_lines", i), {5'd0, cf}, {5'd0, tbl[i].code});
    end
    // round-robin vs fixed with lines 0..2 held high
    do_reset();
    cyc(8'h07, 1'b1);
    chk("rr_first_valid", {7'd0, vr}, 8'd0);
    for (int k = 0; k < 5; k++) begin
      cyc(8'h07, 1'b1);
      chk($sformatf("rr%0d_valid", k), {7'd0, vr}, 8'd1);
      chk($sformatf("rr%0d_lines", k), {5'd0, cr}, {5'd0, rr_exp[k]});
      chk($sformatf("rr%0d_dropped", k), {7'd0, dr}, 8'd1);
      chk($sformatf("fx%0d_lines", k), {5'd0, cf}, {5'd0, fx_exp[k]});
    end
    // async reset while a code is on offer and a drop pulse is active
    do_reset();
    cyc(8'hF0, 1'b0);
    cyc(8'h10, 1'b0);
    chk("pre_rst_valid", {7'd0, vf}, 8'd1);
    chk("pre_rst_lines", {5'd0, cf}, 8'd4);
    chk("pre_rst_dropped", {7'd0, df}, 8'd1);
    in_lines = '0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", {7'd0, vf}, 8'd0);
    chk("arst_lines", {5'd0, cf}, 8'd0);
    chk("arst_dropped", {7'd0, df}, 8'd0);
    chk("arst_busy", {7'd0, bf}, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cyc(8'h00, 1'b1);
      chk($sformatf("post_rst%0d_valid", k), {7'd0, vf}, 8'd0);
      chk($sformatf("post_rst%0d_busy", k), {7'd0, bf}, 8'd0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
